cm_sort_drain: RTL and testbench
================================

// Module: cm_sort_drain
// PURPOSE
//  Consumer end of the cm_sort output interface. Captures complete sorted vectors
//  (vld + DCNT x DWIDTH data, no backpressure) into a small vector FIFO.
//  Streams each vector out element by element, ascending (index 0 first), on a
//  valid/ready interface. Sits between cm_sort and any serial consumer.
// PARAMETERS
//  DCNT     4   elements per vector (>= 2)
//  DWIDTH   16  bits per element
//  BUF_CNT  2   vectors held in the FIFO (power of 2, >= 2)
// PORTS
//  i_clk    in   1              clock
//  i_rst    in   1              synchronous reset, active-high
//  i_vld    in   1              input vector valid (single-cycle, no ready)
//  i_data   in   DCNT*DWIDTH    sorted vector, [DCNT-1:0][DWIDTH-1:0], element 0 smallest
//  o_vld    out  1              output element valid
//  o_rdy    in   1              downstream ready
//  o_data   out  DWIDTH         output element
//  o_last   out  1              final element of the current vector
//  o_ovf    out  1              sticky: an input vector was dropped
//  o_cnt    out  $clog2(BUF_CNT+1)  vectors currently buffered, including the one streaming
// BEHAVIOUR
//  - Reset: o_vld=0, o_data=0, o_last=0, o_ovf=0, o_cnt=0, FIFO pointers=0, element index=0.
//    Reset mid-stream discards all buffered vectors; no partial output after reset.
//  - Push: i_vld && (not full || pop this cycle) -> vector written at wr_ptr; wr_ptr
//    wraps modulo BUF_CNT.
//  - Drop: i_vld && full && no pop this cycle -> vector dropped; o_ovf=1 from the next
//    cycle until reset.
//  - Pop: occurs on the handshake of the last element of the head vector
//    (o_vld && o_rdy && o_last). rd_ptr advances; index returns to 0.
//  - Simultaneous push and pop when full: both take effect; o_cnt is unchanged.
//  - Output is registered: a vector pushed into an empty FIFO at edge N gives o_vld=1
//    with element 0 after edge N+1 (1-cycle latency).
//  - Handshake: o_data and o_last hold stable while o_vld && !o_rdy.
//    o_vld never drops without a handshake.
//  - On a handshake of element k (not last), element k+1 is presented the next cycle.
//    Back-to-back vectors run with no bubble: after the last of vector A, element 0 of
//    B follows the next cycle if B is buffered.
//  - State machine:
//      IDLE   -> LOAD   when the FIFO is non-empty
//      LOAD   -> STREAM once the element register is filled
//      STREAM -> LOAD   on last-handshake when more vectors are buffered
//      STREAM -> IDLE   on last-handshake when the FIFO becomes empty
//  - o_last=1 when index == DCNT-1. o_cnt counts pushes minus pops.
// CONFIGURATION
//  CM_SORT_DRAIN_DEDUP_EN defined:
//   - Element k is skipped when it equals element k-1 of the same vector. A skipped
//     element costs one cycle with o_vld=0.
//   - o_last=1 on the element where elem[k] == elem[DCNT-1]; lookahead is valid
//     because input is sorted. Any remaining elements are discarded and the vector
//     is popped on that handshake.
//   - Element 0 is always emitted.
//  Undefined: every element is emitted; o_last only at index DCNT-1.
// STRUCTURE
//  - cm_pkg: typedef cm_sort_drain_state_e {IDLE, LOAD, STREAM}.
//  - Element vector typedef is a parameterised local typedef (width depends on
//    DCNT and DWIDTH).
//  - Sub-module cm_vec_fifo: BUF_CNT x (DCNT*DWIDTH) register FIFO with push/pop,
//    full/empty and count. Reusable by other cm_ blocks.
//  - cm_sort_drain holds the FSM, index counter, output register, overflow flag and
//    dedup logic.
// TESTING
//  1. DCNT=4, push {1,2,3,4}, o_rdy=1 -> o_data 1,2,3,4 on 4 consecutive cycles;
//     o_last with 4; first o_vld 1 cycle after push.
//  2. Push {5,6,7,8}; o_rdy low on cycles 2-4 -> element 6 held stable; stream resumes
//     with 7; no loss or duplicate.
//  3. BUF_CNT=2, o_rdy=0, push 3 vectors -> third dropped, o_ovf=1, o_cnt=2.
//     Release o_rdy -> only the first two vectors are streamed.
//  4. Full FIFO; push coincides with last-handshake -> push accepted, o_ovf stays 0,
//     o_cnt stays 2.
//  5. Reset asserted mid-vector (after element 1) -> next cycle o_vld=0, o_cnt=0.
//     New push streams from element 0.
//  6. DEDUP_EN, push {3,3,7,7}:
//     - dedup on -> output 3, 7, with o_last on 7.
//     - dedup off -> output 3, 3, 7, 7.

Source files
------------

// File: rtl/cm_pkg.sv
// cm_pkg: shared types for the cm_ block family
package cm_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM} cm_sort_drain_state_e;
endpackage

// File: rtl/cm_vec_fifo.sv
// cm_vec_fifo: DEPTH x W register FIFO with head/next peek, full/empty and count
module cm_vec_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_head,
  output logic [W-1:0]  o_next,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_cnt
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (i_push) mem_d[wr_q] = i_data;
    wr_d = i_push ? wr_q + PW'(1) : wr_q;
    rd_d = i_pop ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + CW'(i_push) - CW'(i_pop);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // Pointers wrap naturally because DEPTH is a power of two
  assign o_head = mem_q[rd_q];
  assign o_next = mem_q[rd_q + PW'(1)];
  assign o_full = cnt_q == CW'(DEPTH);
  assign o_empty = cnt_q == '0;
  assign o_cnt = cnt_q;
endmodule

// File: rtl/cm_sort_drain.sv
// cm_sort_drain: buffers sorted vectors and streams them element by element on valid/ready
// Optional duplicate suppression is enabled by defining CM_SORT_DRAIN_DEDUP_EN.
module cm_sort_drain
  import cm_pkg::*;
#(
  parameter int DCNT = 4,
  parameter int DWIDTH = 16,
  parameter int BUF_CNT = 2,
  localparam int CW = $clog2(BUF_CNT + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_vld,
  input  logic [DCNT*DWIDTH-1:0] i_data,
  output logic                   o_vld,
  input  logic                   o_rdy,
  output logic [DWIDTH-1:0]      o_data,
  output logic                   o_last,
  output logic                   o_ovf,
  output logic [CW-1:0]          o_cnt
);
  localparam int IW = $clog2(DCNT);
`ifdef CM_SORT_DRAIN_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif
  typedef logic [DCNT-1:0][DWIDTH-1:0] vec_t;
  cm_sort_drain_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, nidx;
  logic vld_q, vld_d, last_q, last_d, ovf_q, ovf_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic full, empty, push, pop, hs, drop;
  vec_t head, nxt;
  // Sorted input lets "equals the final element" stand in for "nothing new remains"
  function automatic logic is_last(vec_t v, logic [IW-1:0] i);
    return DEDUP ? v[i] == v[DCNT-1] : i == IW'(DCNT - 1);
  endfunction
  function automatic logic is_dup(vec_t v, logic [IW-1:0] i);
    return DEDUP && v[i] == v[i-IW'(1)];
  endfunction
  assign hs = vld_q && o_rdy;
  assign pop = hs && last_q;
  assign push = i_vld && (!full || pop);
  assign drop = i_vld && full && !pop;
  cm_vec_fifo #(.W(DCNT * DWIDTH), .DEPTH(BUF_CNT)) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (push),
    .i_pop  (pop),
    .i_data (i_data),
    .o_head (head),
    .o_next (nxt),
    .o_full (full),
    .o_empty(empty),
    .o_cnt  (o_cnt)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    vld_d = vld_q;
    data_d = data_q;
    last_d = last_q;
    ovf_d = ovf_q | drop;
    nidx = idx_q + IW'(1);
    if (state_q == IDLE) begin
      if (!empty) begin
        state_d = LOAD;
        idx_d = '0;
        vld_d = 1'b1;
        data_d = head[0];
        last_d = is_last(head, '0);
      end
    end else if (pop) begin
      state_d = o_cnt > CW'(1) ? LOAD : IDLE;
      idx_d = '0;
      vld_d = o_cnt > CW'(1);
      data_d = o_cnt > CW'(1) ? nxt[0] : '0;
      last_d = o_cnt > CW'(1) ? is_last(nxt, '0) : 1'b0;
    end else begin
      if (state_q == LOAD) state_d = STREAM;
      // A skipped duplicate sits for one cycle with vld low, then advances unconditionally
      if (hs || !vld_q) begin
        idx_d = nidx;
        vld_d = !is_dup(head, nidx);
        data_d = head[nidx];
        last_d = is_last(head, nidx);
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      vld_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      vld_q <= vld_d;
      data_q <= data_d;
      last_q <= last_d;
      ovf_q <= ovf_d;
    end
  end
  assign o_vld = vld_q;
  assign o_data = data_q;
  assign o_last = last_q;
  assign o_ovf = ovf_q;
endmodule

// File: tb/tb_cm_sort_drain.sv
// tb_cm_sort_drain: directed vectors, expected elements queued and checked by a monitor thread
module tb_cm_sort_drain;
  logic clk = 1'b0, i_rst = 1'b1, i_vld = 1'b0, o_rdy = 1'b0;
  logic [63:0] i_data = '0;
  logic o_vld, o_last, o_ovf;
  logic [15:0] o_data;
  logic [1:0] o_cnt;
  logic [16:0] q[$];
  int checks = 0, failures = 0;

  cm_sort_drain dut (
    .i_clk (clk),
    .i_rst (i_rst),
    .i_vld (i_vld),
    .i_data(i_data),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .o_data(o_data),
    .o_last(o_last),
    .o_ovf (o_ovf),
    .o_cnt (o_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_el(input logic [15:0] d, input logic l);
    q.push_back({l, d});
  endtask

  task automatic exp4(input logic [15:0] a, b, c, d);
    exp_el(a, 0); exp_el(b, 0); exp_el(c, 0); exp_el(d, 1);
  endtask

  task automatic push4(input logic [15:0] a, b, c, d);
    i_vld = 1'b1;
    i_data = {d, c, b, a};
    tick();
    i_vld = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    chk("rst_state", {o_vld, o_last, o_ovf, o_cnt, o_data}, 0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && (q.size() != 0 || o_vld); i++) tick();
    chk(name, {q.size() != 0, o_vld}, 0);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (o_vld) begin
        if (q.size() == 0) chk("unexpected_elem", {o_last, o_data}, 32'h1ffff);
        else chk("elem", {o_last, o_data}, q[0]);
        if (o_rdy && q.size() != 0) void'(q.pop_front());
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    do_reset();
    // 1: basic stream with one-cycle latency
    o_rdy = 1'b1;
    exp4(1, 2, 3, 4);
    push4(1, 2, 3, 4);
    chk("t1_latency_vld0", o_vld, 0);
    chk("t1_cnt", o_cnt, 1);
    tick();
    chk("t1_first", {o_vld, o_data}, {1'b1, 16'd1});
    repeat (4) tick();
    chk("t1_done", {q.size() != 0, o_vld, o_cnt}, 0);
    // 2: backpressure holds element 6
    exp4(5, 6, 7, 8);
    push4(5, 6, 7, 8);
    tick();
    tick();
    o_rdy = 1'b0;
    repeat (3) tick();
    chk("t2_hold", {o_vld, o_last, o_data}, {1'b1, 1'b0, 16'd6});
    o_rdy = 1'b1;
    tick();
    chk("t2_resume", o_data, 7);
    drain("t2_drain");
    // 3: overflow with full FIFO
    o_rdy = 1'b0;
    exp4(10, 11, 12, 13);
    exp4(20, 21, 22, 23);
    push4(10, 11, 12, 13);
    push4(20, 21, 22, 23);
    chk("t3_no_ovf_yet", {o_ovf, o_cnt}, {1'b0, 2'd2});
    push4(30, 31, 32, 33);
    chk("t3_ovf", {o_ovf, o_cnt}, {1'b1, 2'd2});
    o_rdy = 1'b1;
    drain("t3_drain");
    chk("t3_ovf_sticky", {o_ovf, o_cnt}, {1'b1, 2'd0});
    do_reset();
    // 4: push coinciding with last handshake while full
    o_rdy = 1'b0;
    exp4(41, 42, 43, 44);
    exp4(51, 52, 53, 54);
    exp4(61, 62, 63, 64);
    push4(41, 42, 43, 44);
    push4(51, 52, 53, 54);
    chk("t4_full", {o_vld, o_data, o_cnt}, {1'b1, 16'd41, 2'd2});
    o_rdy = 1'b1;
    repeat (3) tick();
    chk("t4_at_last", {o_last, o_data}, {1'b1, 16'd44});
    push4(61, 62, 63, 64);
    chk("t4_cnt_ovf", {o_ovf, o_cnt}, {1'b0, 2'd2});
    chk("t4_no_bubble", {o_vld, o_data}, {1'b1, 16'd51});
    drain("t4_drain");
    // 5: reset mid-vector discards everything buffered
    exp_el(70, 0);
    exp_el(71, 0);
    push4(70, 71, 72, 73);
    push4(80, 81, 82, 83);
    tick();
    chk("t5_mid", {o_data, o_cnt}, {16'd71, 2'd2});
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("t5_after_rst", {o_vld, o_cnt}, 0);
    tick();
    chk("t5_still_idle", {o_vld, o_cnt}, 0);
    exp4(90, 91, 92, 93);
    push4(90, 91, 92, 93);
    tick();
    chk("t5_restart", {o_vld, o_data}, {1'b1, 16'd90});
    drain("t5_drain");
    // 6: duplicates
`ifdef CM_SORT_DRAIN_DEDUP_EN
    exp_el(3, 0);
    exp_el(7, 1);
    exp_el(9, 1);
`else
    exp4(3, 3, 7, 7);
    exp4(9, 9, 9, 9);
`endif
    push4(3, 3, 7, 7);
    push4(9, 9, 9, 9);
    drain("t6_drain");
    chk("t6_end", {o_ovf, o_cnt}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
